// File: rtl/encoder_4to2_arb_pkg.sv
// Shared widths, FSM state type and a bit-count helper for the 4-to-2 request encoder.
package encoder_pkg;

  localparam int N_REQ = 4;
  localparam int IDX_W = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  function automatic logic [IDX_W:0] count_ones(input logic [N_REQ-1:0] v);
    logic [IDX_W:0] cnt;
    cnt = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cnt = cnt + (IDX_W+1)'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/encoder_4to2_arb_prio_sel_4.sv
// Combinational 4-way priority selector: searches base, base-1, base-2, base-3 (mod 4)
// and reports the first set request plus whether any / more than one request is set.
module prio_sel_4
  import encoder_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] base,
  output logic [IDX_W-1:0] idx,
  output logic             any,
  output logic             multi
);

  logic [IDX_W-1:0] cand;
  logic             found;

  always_comb begin
    idx   = '0;
    cand  = '0;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = base - IDX_W'(k);
      if (!found && req[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end

  assign any   = |req;
  assign multi = (count_ones(req) > (IDX_W+1)'(1));

endmodule

// File: rtl/encoder_4to2_arb.sv
// Registered 4-to-2 request encoder with valid/ack handshake and sticky pending bits.
// Define ROUND_ROBIN_EN for rotating priority; otherwise highest index wins.
module encoder_4to2_arb
  import encoder_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [N_REQ-1:0] D,
  input  logic             ack,
  output logic             A,
  output logic             B,
  output logic             valid,
  output logic             more
);

  state_t           state_q, state_d;
  logic [N_REQ-1:0] pending_q;
  logic [N_REQ-1:0] clr;
  logic [IDX_W-1:0] gnt_idx_q;
  logic             more_q;
  logic [IDX_W-1:0] base;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_any;
  logic             sel_multi;
  logic             grant_load;
  logic             accept;

`ifdef ROUND_ROBIN_EN
  // rot_q is stored as an offset from index 3 so that the reset value 0 starts
  // at the same priority as the fixed scheme; base = 3 - rot_q.
  logic [IDX_W-1:0] rot_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rot_q <= '0;
    end else if (accept) begin
      rot_q <= IDX_W'(0) - gnt_idx_q;
    end
  end

  assign base = IDX_W'(N_REQ-1) - rot_q;
`else
  assign base = IDX_W'(N_REQ-1);
`endif

  prio_sel_4 u_sel (
    .req   (pending_q),
    .base  (base),
    .idx   (sel_idx),
    .any   (sel_any),
    .multi (sel_multi)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_load = 1'b0;
    accept     = 1'b0;
    case (state_q)
      IDLE: begin
        if (en && sel_any) begin
          grant_load = 1'b1;
          state_d    = GRANT;
        end
      end
      GRANT: begin
        if (ack) begin
          accept  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A new request on the granted line in the ack cycle overrides the clear.
  assign clr = accept ? (N_REQ'(1) << gnt_idx_q) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
    end else begin
      pending_q <= (pending_q & ~clr) | (D & {N_REQ{en}});
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_idx_q <= '0;
      more_q    <= 1'b0;
    end else if (grant_load) begin
      gnt_idx_q <= sel_idx;
      more_q    <= sel_multi;
    end else if (accept) begin
      more_q    <= 1'b0;
    end
  end

  assign A     = gnt_idx_q[1];
  assign B     = gnt_idx_q[0];
  assign valid = (state_q == GRANT);
  assign more  = more_q;

endmodule

// File: tb/tb_encoder_4to2_arb.sv
// Scenario bench for encoder_4to2_arb: expected grants are queued as stimulus is applied
// and popped when the DUT raises valid.
module tb_encoder_4to2_arb;
  import encoder_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [3:0] D;
  logic       ack;
  logic       A, B, valid, more;

  typedef struct packed {
    logic [1:0] idx;
    logic       more;
  } grant_t;

  grant_t exp_q[$];
  int tests_run;
  int tests_failed;

  encoder_4to2_arb dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .D     (D),
    .ack   (ack),
    .A     (A),
    .B     (B),
    .valid (valid),
    .more  (more)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic wait_grant(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (valid) ok = 1'b1;
    end
  endtask

  task automatic do_ack();
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; D = 4'b1111; ack = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({valid, A, B, more} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %b expected 0000", {valid, A, B, more});
    end
    D = 4'b0000;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if (valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_no_pending: valid=%b expected 0", valid);
    end
  endtask

  task automatic test_single();
    grant_t e;
    exp_q.push_back('{idx: 2'd2, more: 1'b0});
    en = 1'b1; D = 4'b0100;
    @(negedge clk);
    D = 4'b0000;
    tests_run++;
    if (valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_latency_early: valid=%b expected 0", valid);
    end
    @(negedge clk);
    e = exp_q.pop_front();
    tests_run++;
    if ({valid, A, B, more} !== {1'b1, e.idx, e.more}) begin
      tests_failed++;
      $display("FAIL single_grant: got %b expected %b", {valid, A, B, more}, {1'b1, e.idx, e.more});
    end
    repeat (3) @(negedge clk);
    tests_run++;
    if ({valid, A, B, more} !== {1'b1, e.idx, e.more}) begin
      tests_failed++;
      $display("FAIL single_hold: got %b expected %b", {valid, A, B, more}, {1'b1, e.idx, e.more});
    end
    do_ack();
    tests_run++;
    if (valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_ack_drop: valid=%b expected 0", valid);
    end
  endtask

  task automatic test_two_pending();
    grant_t e;
    bit ok;
    exp_q.push_back('{idx: 2'd3, more: 1'b1});
    exp_q.push_back('{idx: 2'd1, more: 1'b0});
    D = 4'b1010;
    @(negedge clk);
    D = 4'b0000;
    wait_grant(ok);
    e = exp_q.pop_front();
    tests_run++;
    if (!ok || {A, B, more} !== {e.idx, e.more}) begin
      tests_failed++;
      $display("FAIL two_first: ok=%0d got %b expected %b", ok, {A, B, more}, {e.idx, e.more});
    end
    do_ack();
    tests_run++;
    if (valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL two_bubble: valid=%b expected 0", valid);
    end
    @(negedge clk);
    e = exp_q.pop_front();
    tests_run++;
    if ({valid, A, B, more} !== {1'b1, e.idx, e.more}) begin
      tests_failed++;
      $display("FAIL two_second: got %b expected %b", {valid, A, B, more}, {1'b1, e.idx, e.more});
    end
    do_ack();
  endtask

  task automatic test_en_low();
    grant_t e;
    bit ok;
    en = 1'b0; D = 4'b0001;
    @(negedge clk);
    D = 4'b0000;
    repeat (3) @(negedge clk);
    tests_run++;
    if (valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL en_low_capture: valid=%b expected 0", valid);
    end
    en = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if (valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL en_high_no_req: valid=%b expected 0", valid);
    end
    // capture with en high, then drop en before the grant edge: bit must be retained
    exp_q.push_back('{idx: 2'd0, more: 1'b0});
    D = 4'b0001;
    @(negedge clk);
    D = 4'b0000; en = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL en_low_no_grant: valid=%b expected 0", valid);
    end
    en = 1'b1;
    wait_grant(ok);
    e = exp_q.pop_front();
    tests_run++;
    if (!ok || {A, B, more} !== {e.idx, e.more}) begin
      tests_failed++;
      $display("FAIL en_retained: ok=%0d got %b expected %b", ok, {A, B, more}, {e.idx, e.more});
    end
    en = 1'b0;
    do_ack();
    tests_run++;
    if (valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL en_low_handshake: valid=%b expected 0", valid);
    end
    en = 1'b1;
  endtask

  task automatic test_set_wins();
    grant_t e;
    bit ok;
    exp_q.push_back('{idx: 2'd2, more: 1'b0});
    exp_q.push_back('{idx: 2'd2, more: 1'b0});
    D = 4'b0100;
    @(negedge clk);
    D = 4'b0000;
    wait_grant(ok);
    e = exp_q.pop_front();
    tests_run++;
    if (!ok || {A, B, more} !== {e.idx, e.more}) begin
      tests_failed++;
      $display("FAIL setwins_first: ok=%0d got %b expected %b", ok, {A, B, more}, {e.idx, e.more});
    end
    D = 4'b0100;
    do_ack();
    D = 4'b0000;
    @(negedge clk);
    e = exp_q.pop_front();
    tests_run++;
    if ({valid, A, B, more} !== {1'b1, e.idx, e.more}) begin
      tests_failed++;
      $display("FAIL setwins_regrant: got %b expected %b", {valid, A, B, more}, {1'b1, e.idx, e.more});
    end
    do_ack();
  endtask

  task automatic test_priority_order();
    grant_t e;
    bit ok;
    pulse_reset();
    en = 1'b1;
`ifdef ROUND_ROBIN_EN
    exp_q.push_back('{idx: 2'd3, more: 1'b1});
    exp_q.push_back('{idx: 2'd2, more: 1'b1});
    exp_q.push_back('{idx: 2'd1, more: 1'b1});
    exp_q.push_back('{idx: 2'd0, more: 1'b1});
    exp_q.push_back('{idx: 2'd3, more: 1'b1});
`else
    exp_q.push_back('{idx: 2'd3, more: 1'b1});
    exp_q.push_back('{idx: 2'd3, more: 1'b1});
    exp_q.push_back('{idx: 2'd3, more: 1'b1});
`endif
    D = 4'b1111;
    while (exp_q.size() != 0) begin
      wait_grant(ok);
      e = exp_q.pop_front();
      tests_run++;
      if (!ok || {A, B, more} !== {e.idx, e.more}) begin
        tests_failed++;
        $display("FAIL prio_order: ok=%0d got %b expected %b", ok, {A, B, more}, {e.idx, e.more});
      end
      do_ack();
    end
    D = 4'b0000;
  endtask

  task automatic test_reset_mid_grant();
    grant_t e;
    bit ok;
    pulse_reset();
    en = 1'b1;
    exp_q.push_back('{idx: 2'd3, more: 1'b1});
    D = 4'b1011;
    @(negedge clk);
    D = 4'b0000;
    wait_grant(ok);
    e = exp_q.pop_front();
    tests_run++;
    if (!ok || {A, B, more} !== {e.idx, e.more}) begin
      tests_failed++;
      $display("FAIL midreset_grant: ok=%0d got %b expected %b", ok, {A, B, more}, {e.idx, e.more});
    end
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({valid, A, B, more} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL midreset_async: got %b expected 0000", {valid, A, B, more});
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    tests_run++;
    if (valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset_pending_lost: valid=%b expected 0", valid);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n = 1'b0; en = 1'b0; D = 4'b0000; ack = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_two_pending();
    test_en_low();
    test_set_wins();
    test_priority_order();
    test_reset_mid_grant();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
